aes_result_writer: RTL and testbench
====================================

// Module: aes_result_writer
// PURPOSE
//  Downstream stage of the AES core wrapper: captures each 128-bit ciphertext result and writes it to BRAM as four
//  32-bit words. Words go to consecutive byte addresses starting at an AXI-programmed destination.
//  Signals job completion back to the AXI register block. A small result FIFO decouples core strobes from BRAM stalls.
// PARAMETERS
//  FIFO_DEPTH  2   128-bit result entries buffered (power of two, >=2)
//  ADDR_W      32  BRAM byte-address width
// PORTS
//  aes_clk          in   1        sole clock, rising edge
//  aes_rst_n        in   1        asynchronous active-low reset
//  wr_start         in   1        1-cycle pulse: arm a job (sampled only in IDLE)
//  wr_addr_start    in   ADDR_W   destination byte address of first word, sampled with wr_start
//  wr_num_chunks    in   32       results to write this job, sampled with wr_start
//  result_valid     in   1        1-cycle strobe: result_data holds a new ciphertext
//  result_data      in   128      ciphertext block
//  bram_en          out  1        BRAM write request
//  bram_we          out  4        byte enables: 4'hF when bram_en, else 4'h0
//  bram_addr        out  ADDR_W   BRAM byte address
//  bram_wdata       out  32       BRAM write data
//  bram_ready       in   1        BRAM accepts the request this cycle
//  wr_busy          out  1        job armed or writing
//  wr_done          out  1        1-cycle pulse: last word of job accepted
//  wr_overflow      out  1        sticky: a result was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0. State IDLE. FIFO empty. Counters 0.
//  FSM: IDLE -> ARMED on wr_start.
//   ARMED -> WRITE when FIFO non-empty.
//   WRITE -> ARMED after word 3 is accepted and chunks remain.
//   WRITE -> DONE after word 3 is accepted and no chunks remain.
//   DONE -> IDLE next cycle, with wr_done=1 for that one cycle.
//  wr_start in IDLE also:
//   - loads addr_ptr <= wr_addr_start and chunk_rem <= wr_num_chunks;
//   - clears wr_overflow.
//  wr_num_chunks==0: IDLE -> DONE directly. wr_done pulses 2 cycles after wr_start; no BRAM writes.
//  wr_start outside IDLE is ignored. Parameters already latched are unchanged.
//  result_valid outside ARMED/WRITE is ignored and does not set overflow.
//  result_valid in ARMED/WRITE pushes result_data, except when the FIFO is full:
//   - full with no pop in the same cycle: entry dropped, wr_overflow <= 1;
//   - full with a pop in the same cycle: push accepted.
//  WRITE word order: word k = result_data[127-32k -: 32], k=0..3 (MSW first, at lowest address).
//  bram_en is held with stable addr/wdata until bram_ready; transfer = bram_en & bram_ready.
//  Each transfer: addr_ptr += 4 (mod 2^ADDR_W, wrap-around allowed), word index k += 1.
//  Transfer of k==3: FIFO pop, chunk_rem -= 1.
//  Throughput: 1 word/cycle with bram_ready=1. First bram_en 1 cycle after the FIFO becomes non-empty in ARMED.
//  Latency, result_valid to first bram_en in ARMED with empty FIFO: 2 cycles.
//  Results arriving after chunk_rem reaches 0 are not written. FIFO is flushed on DONE.
//  wr_busy = (state==ARMED)|(state==WRITE).
//  Reset mid-transfer: job aborted, FIFO flushed, outputs 0 immediately. No partial-job recovery.
// STRUCTURE
//  aes_pkg (shared): AES_BLOCK_W=128, AES_WORD_W=32, AES_WORDS_PER_BLOCK=4, writer state localparams.
//  Sub-module aes_result_fifo:
//   - synchronous FIFO, DEPTH x 128;
//   - push/pop/full/empty ports;
//   - pointers one bit wider than log2(DEPTH) to distinguish full from empty.
//  Top holds the FSM, addr_ptr, chunk_rem, word index k and the output registers.
// TESTING
//  T1: start addr=0x1000, chunks=1; one strobe, data=0x00112233_44556677_8899AABB_CCDDEEFF; ready=1
//      -> 4 writes on consecutive cycles: 0x1000:00112233, 0x1004:44556677, 0x1008:8899AABB, 0x100C:CCDDEEFF;
//      -> wr_done 1 cycle after the last write.
//  T2: chunks=3, strobes 2 cycles apart, ready toggling 1010...
//      -> 12 writes to 0x1000..0x102C in order; addr/wdata stable while ready=0; no overflow.
//  T3: FIFO_DEPTH=2, ready=0, 3 strobes
//      -> wr_overflow=1; after ready=1 only the first 2 blocks are written; flag clears on next wr_start.
//  T4: chunks=0 -> wr_done exactly 2 cycles after wr_start; bram_en never asserted.
//  T5: addr=0xFFFF_FFF8, chunks=1 -> words at FFFFFFF8, FFFFFFFC, 00000000, 00000004.
//  T6: assert reset while k==2 -> all outputs 0 within the same cycle.
//      Then a new job with chunks=1 writes all 4 words and pulses wr_done correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block/word geometry and result-writer state encoding
package aes_pkg;

   localparam int AES_BLOCK_W         = 128;
   localparam int AES_WORD_W          = 32;
   localparam int AES_WORDS_PER_BLOCK = 4;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_ARMED = 2'd1,
      WR_WRITE = 2'd2,
      WR_DONE  = 2'd3
   } wr_state_e;

   // Word 0 is the most significant word of the block.
   function automatic logic [AES_WORD_W-1:0] block_word(input logic [AES_BLOCK_W-1:0] blk,
                                                        input logic [1:0]             k);
      return blk[AES_BLOCK_W-1-AES_WORD_W*int'(k) -: AES_WORD_W];
   endfunction

endpackage

// File: rtl/aes_result_writer_if.sv
// rtl/aes_result_writer_if.sv - BRAM write-port bundle between result writer and memory
interface aes_result_writer_if
   import aes_pkg::*;
#(
   parameter int ADDR_W = 32
);
   logic                  bram_en;
   logic [3:0]            bram_we;
   logic [ADDR_W-1:0]     bram_addr;
   logic [AES_WORD_W-1:0] bram_wdata;
   logic                  bram_ready;

   modport master (output bram_en, bram_we, bram_addr, bram_wdata, input bram_ready);
   modport slave  (input bram_en, bram_we, bram_addr, bram_wdata, output bram_ready);
endinterface

// File: rtl/aes_result_fifo.sv
// rtl/aes_result_fifo.sv - synchronous result FIFO, head visible combinationally on pop_data
module aes_result_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // A push into a full FIFO only happens alongside a pop, so overwriting the head slot is safe.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/aes_result_writer.sv
// rtl/aes_result_writer.sv - buffers 128-bit AES results and writes them to BRAM as four 32-bit words
module aes_result_writer
   import aes_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_W     = 32
) (
   input  logic                   aes_clk,
   input  logic                   aes_rst_n,
   input  logic                   wr_start,
   input  logic [ADDR_W-1:0]      wr_addr_start,
   input  logic [31:0]            wr_num_chunks,
   input  logic                   result_valid,
   input  logic [AES_BLOCK_W-1:0] result_data,
   aes_result_writer_if.master    bram,
   output logic                   wr_busy,
   output logic                   wr_done,
   output logic                   wr_overflow
);
   localparam logic [1:0] LAST_WORD = 2'(AES_WORDS_PER_BLOCK - 1);

   wr_state_e              state_q, state_d;
   logic [ADDR_W-1:0]      addr_ptr_q, addr_ptr_d;
   logic [31:0]            chunk_rem_q, chunk_rem_d;
   logic [1:0]             k_q, k_d;
   logic                   overflow_q, overflow_d;
   logic                   zero_pend_q, zero_pend_d;
   logic                   fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [AES_BLOCK_W-1:0] fifo_head;
   logic                   active, bram_en, xfer;

   assign active  = (state_q == WR_ARMED) || (state_q == WR_WRITE);
   assign bram_en = (state_q == WR_WRITE);
   assign xfer    = bram_en && bram.bram_ready;

   always_comb begin
      state_d     = state_q;
      addr_ptr_d  = addr_ptr_q;
      chunk_rem_d = chunk_rem_q;
      k_d         = k_q;
      overflow_d  = overflow_q;
      zero_pend_d = zero_pend_q;
      fifo_pop    = 1'b0;
      fifo_flush  = 1'b0;
      fifo_push   = 1'b0;
      unique case (state_q)
         WR_IDLE: begin
            // An empty job spends one extra cycle in IDLE so wr_done lands two cycles after wr_start.
            if (zero_pend_q) begin
               zero_pend_d = 1'b0;
               state_d     = WR_DONE;
            end else if (wr_start) begin
               addr_ptr_d  = wr_addr_start;
               chunk_rem_d = wr_num_chunks;
               overflow_d  = 1'b0;
               k_d         = '0;
               if (wr_num_chunks == '0) zero_pend_d = 1'b1;
               else                     state_d     = WR_ARMED;
            end
         end
         WR_ARMED: begin
            if (!fifo_empty) begin
               state_d = WR_WRITE;
               k_d     = '0;
            end
         end
         WR_WRITE: begin
            if (xfer) begin
               addr_ptr_d = addr_ptr_q + ADDR_W'(4);
               k_d        = k_q + 2'd1;
               if (k_q == LAST_WORD) begin
                  fifo_pop    = 1'b1;
                  chunk_rem_d = chunk_rem_q - 32'd1;
                  state_d     = (chunk_rem_q == 32'd1) ? WR_DONE : WR_ARMED;
               end
            end
         end
         WR_DONE: begin
            fifo_flush = 1'b1;
            state_d    = WR_IDLE;
         end
         default: state_d = WR_IDLE;
      endcase
      if (active && result_valid) begin
         if (!fifo_full || fifo_pop) fifo_push  = 1'b1;
         else                        overflow_d = 1'b1;
      end
   end

   always_ff @(posedge aes_clk or negedge aes_rst_n) begin
      if (!aes_rst_n) begin
         state_q     <= WR_IDLE;
         addr_ptr_q  <= '0;
         chunk_rem_q <= '0;
         k_q         <= '0;
         overflow_q  <= 1'b0;
         zero_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_ptr_q  <= addr_ptr_d;
         chunk_rem_q <= chunk_rem_d;
         k_q         <= k_d;
         overflow_q  <= overflow_d;
         zero_pend_q <= zero_pend_d;
      end
   end

   aes_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (AES_BLOCK_W)
   ) u_fifo (
      .clk       (aes_clk),
      .rst_n     (aes_rst_n),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .push_data (result_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bram.bram_en    = bram_en;
   assign bram.bram_we    = {4{bram_en}};
   assign bram.bram_addr  = bram_en ? addr_ptr_q : '0;
   assign bram.bram_wdata = bram_en ? block_word(fifo_head, k_q) : '0;

   assign wr_busy     = active;
   assign wr_done     = (state_q == WR_DONE);
   assign wr_overflow = overflow_q;
endmodule

// File: tb/tb_aes_result_writer.sv
// tb/tb_aes_result_writer.sv - randomized self-checking bench for aes_result_writer
module tb_aes_result_writer;
   import aes_pkg::*;

   localparam int DEPTH = 2;
   localparam int AW    = 32;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } xfer_t;

   logic         aes_clk = 1'b0;
   logic         aes_rst_n = 1'b1;
   logic         wr_start = 1'b0;
   logic [31:0]  wr_addr_start = '0;
   logic [31:0]  wr_num_chunks = '0;
   logic         result_valid = 1'b0;
   logic [127:0] result_data = '0;
   logic         wr_busy, wr_done, wr_overflow;

   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    ready_mode = 3;
   logic  ready_r = 1'b0;
   xfer_t obs[$];
   xfer_t exp_q[$];
   int    done_q[$];
   int    rv_q[$];
   int    ws_cyc = 0;
   logic  stall_q = 1'b0;
   logic [63:0] stall_val = '0;

   aes_result_writer_if #(.ADDR_W(AW)) bif ();

   aes_result_writer #(
      .FIFO_DEPTH (DEPTH),
      .ADDR_W     (AW)
   ) dut (
      .aes_clk       (aes_clk),
      .aes_rst_n     (aes_rst_n),
      .wr_start      (wr_start),
      .wr_addr_start (wr_addr_start),
      .wr_num_chunks (wr_num_chunks),
      .result_valid  (result_valid),
      .result_data   (result_data),
      .bram          (bif),
      .wr_busy       (wr_busy),
      .wr_done       (wr_done),
      .wr_overflow   (wr_overflow)
   );

   always #5 aes_clk = ~aes_clk;

   always @(posedge aes_clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge aes_clk) begin
      #1;
      case (ready_mode)
         0:       ready_r = 1'b1;
         1:       ready_r = ~ready_r;
         2:       ready_r = 1'($urandom_range(0, 1));
         default: ready_r = 1'b0;
      endcase
      bif.bram_ready = ready_r;
   end

   // Passive observer: records transfers, done pulses and input strobes with their cycle numbers.
   always @(negedge aes_clk) begin
      if (stall_q)
         check_eq("bram_hold", {bif.bram_en, bif.bram_addr, bif.bram_wdata}, {1'b1, stall_val});
      check_eq("bram_we", bif.bram_we, {4{bif.bram_en}});
      stall_q   = aes_rst_n && bif.bram_en && !bif.bram_ready;
      stall_val = {bif.bram_addr, bif.bram_wdata};
      if (aes_rst_n && bif.bram_en && bif.bram_ready)
         obs.push_back('{bif.bram_addr, bif.bram_wdata, cyc});
      if (wr_done)      done_q.push_back(cyc);
      if (wr_start)     ws_cyc = cyc;
      if (result_valid) rv_q.push_back(cyc);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge aes_clk);
      #1;
   endtask

   task automatic clear_all();
      obs.delete();
      exp_q.delete();
      done_q.delete();
      rv_q.delete();
   endtask

   task automatic start_job(input logic [31:0] addr, input logic [31:0] chunks);
      wr_start      = 1'b1;
      wr_addr_start = addr;
      wr_num_chunks = chunks;
      tick(1);
      wr_start      = 1'b0;
      wr_addr_start = $urandom;
      wr_num_chunks = $urandom;
   endtask

   task automatic strobe(input logic [127:0] blk);
      result_valid = 1'b1;
      result_data  = blk;
      tick(1);
      result_valid = 1'b0;
      result_data  = {4{$urandom}};
   endtask

   task automatic send_when_room(input logic [127:0] blk, input int sent);
      int b = 0;
      while ((sent - obs.size() / 4) >= DEPTH && b < 300) begin
         tick(1);
         b++;
      end
      check_eq("room_timeout", 128'(b >= 300), 128'(0));
      strobe(blk);
   endtask

   task automatic wait_xfers(input string tag, input int n, input int budget);
      int b = 0;
      while (obs.size() < n && b < budget) begin
         tick(1);
         b++;
      end
      check_eq({tag, "_nxfer"}, obs.size(), n);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int b = 0;
      while (done_q.size() < 1 && b < budget) begin
         tick(1);
         b++;
      end
      check_eq({tag, "_done_seen"}, done_q.size(), 1);
   endtask

   task automatic expect_block(input logic [31:0] base, input int idx, input logic [127:0] blk);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] a;
         logic [127:0] sh;
         a  = base + 32'(16 * idx + 4 * k);
         sh = blk >> (96 - 32 * k);
         exp_q.push_back('{a, sh[31:0], 0});
      end
   endtask

   task automatic compare_writes(input string tag);
      check_eq({tag, "_count"}, obs.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         check_eq($sformatf("%s_addr%0d", tag, i), obs[i].addr, exp_q[i].addr);
         check_eq($sformatf("%s_data%0d", tag, i), obs[i].data, exp_q[i].data);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_en"},    bif.bram_en, 0);
      check_eq({tag, "_we"},    bif.bram_we, 0);
      check_eq({tag, "_addr"},  bif.bram_addr, 0);
      check_eq({tag, "_wdata"}, bif.bram_wdata, 0);
      check_eq({tag, "_busy"},  wr_busy, 0);
      check_eq({tag, "_done"},  wr_done, 0);
      check_eq({tag, "_ovf"},   wr_overflow, 0);
   endtask

   initial begin
      logic [127:0] blk;
      logic [127:0] b3 [3];
      logic [31:0]  base;
      int           nch;

      #1 aes_rst_n = 1'b0;
      #1 check_all_zero("reset");
      tick(3);
      aes_rst_n = 1'b1;
      tick(2);

      // T1: single block, ready always high
      clear_all();
      ready_mode = 0;
      tick(1);
      start_job(32'h1000, 1);
      check_eq("t1_busy_armed", wr_busy, 1);
      blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      strobe(blk);
      wait_xfers("t1", 4, 40);
      wait_done("t1", 20);
      expect_block(32'h1000, 0, blk);
      compare_writes("t1");
      for (int i = 0; i < 4 && i < obs.size() && rv_q.size() > 0; i++)
         check_eq($sformatf("t1_cyc%0d", i), obs[i].cyc, rv_q[0] + 2 + i);
      if (obs.size() == 4 && done_q.size() == 1)
         check_eq("t1_done_cyc", done_q[0], obs[3].cyc + 1);
      tick(1);
      check_eq("t1_idle_busy", wr_busy, 0);
      check_eq("t1_ovf", wr_overflow, 0);

      // T2: three chunks, toggling ready, a second wr_start while busy
      clear_all();
      ready_mode = 1;
      start_job(32'h1000, 3);
      for (int i = 0; i < 3; i++) b3[i] = {$urandom, $urandom, $urandom, $urandom};
      strobe(b3[0]);
      start_job(32'h5000, 9);
      strobe(b3[1]);
      send_when_room(b3[2], 2);
      wait_xfers("t2", 12, 200);
      wait_done("t2", 20);
      for (int i = 0; i < 3; i++) expect_block(32'h1000, i, b3[i]);
      compare_writes("t2");
      check_eq("t2_ovf", wr_overflow, 0);
      tick(3);
      check_eq("t2_one_done", done_q.size(), 1);

      // T3: ready held low, third strobe finds the FIFO full
      clear_all();
      ready_mode = 3;
      tick(2);
      start_job(32'h2000, 2);
      for (int i = 0; i < 3; i++) begin
         b3[i] = {$urandom, $urandom, $urandom, $urandom};
         strobe(b3[i]);
      end
      tick(2);
      check_eq("t3_ovf_set", wr_overflow, 1);
      check_eq("t3_no_xfer", obs.size(), 0);
      ready_mode = 0;
      wait_xfers("t3", 8, 60);
      wait_done("t3", 20);
      expect_block(32'h2000, 0, b3[0]);
      expect_block(32'h2000, 1, b3[1]);
      compare_writes("t3");
      tick(1);
      check_eq("t3_ovf_sticky", wr_overflow, 1);

      // T4: empty job, overflow clears on start
      clear_all();
      start_job(32'h7000, 0);
      check_eq("t4_ovf_clear", wr_overflow, 0);
      wait_done("t4", 10);
      if (done_q.size() > 0) check_eq("t4_done_cyc", done_q[0], ws_cyc + 2);
      tick(4);
      check_eq("t4_no_xfer", obs.size(), 0);
      check_eq("t4_one_done", done_q.size(), 1);

      // T5: address wrap-around
      clear_all();
      start_job(32'hFFFF_FFF8, 1);
      blk = {$urandom, $urandom, $urandom, $urandom};
      strobe(blk);
      wait_xfers("t5", 4, 40);
      wait_done("t5", 20);
      expect_block(32'hFFFF_FFF8, 0, blk);
      compare_writes("t5");

      // T6: reset while word 2 is on the bus, then a clean job
      clear_all();
      start_job(32'h3000, 1);
      blk = {$urandom, $urandom, $urandom, $urandom};
      strobe(blk);
      wait_xfers("t6a", 2, 40);
      check_eq("t6_word2", bif.bram_wdata, blk[63:32]);
      aes_rst_n = 1'b0;
      #1 check_all_zero("t6_rst");
      tick(2);
      aes_rst_n = 1'b1;
      tick(1);
      clear_all();
      start_job(32'h4000, 1);
      blk = {$urandom, $urandom, $urandom, $urandom};
      strobe(blk);
      wait_xfers("t6b", 4, 40);
      wait_done("t6b", 20);
      expect_block(32'h4000, 0, blk);
      compare_writes("t6b");
      if (obs.size() == 4 && done_q.size() == 1)
         check_eq("t6_done_cyc", done_q[0], obs[3].cyc + 1);

      // Random jobs with random back-pressure and ignored strobes outside a job
      for (int j = 0; j < 8; j++) begin
         clear_all();
         ready_mode = 2;
         base = $urandom;
         nch  = $urandom_range(1, 4);
         strobe({4{$urandom}});
         start_job(base, 32'(nch));
         for (int i = 0; i < nch; i++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            tick($urandom_range(0, 3));
            send_when_room(blk, i);
            expect_block(base, i, blk);
         end
         wait_xfers($sformatf("rnd%0d", j), 4 * nch, 400);
         wait_done($sformatf("rnd%0d", j), 40);
         strobe({4{$urandom}});
         tick(3);
         compare_writes($sformatf("rnd%0d", j));
         check_eq($sformatf("rnd%0d_ovf", j), wr_overflow, 0);
         check_eq($sformatf("rnd%0d_one_done", j), done_q.size(), 1);
         check_eq($sformatf("rnd%0d_busy", j), wr_busy, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
